// File: rtl/regfile_param_if.sv
// regfile_param_if: decode/issue/writeback bus into the register file and scoreboard
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;
  logic              ctrl_setBusy;
  logic [ADDR_W-1:0] ctrl_busyReg;
  logic              busy_readRegA;
  logic              busy_readRegB;
  logic [ADDR_W:0]   busy_count;
  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
           ctrl_setBusy, ctrl_busyReg,
    input  data_readRegA, data_readRegB, busy_readRegA, busy_readRegB, busy_count
  );
  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
           ctrl_setBusy, ctrl_busyReg,
    output data_readRegA, data_readRegB, busy_readRegA, busy_readRegB, busy_count
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: 2R1W register file with pending-write scoreboard; optional
// same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic            clock,
  input logic            ctrl_reset,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit Z = ZERO_REG != 0;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_count;
  logic              w_we, w_set, w_inc, w_dec, w_zA, w_zB, w_bypA, w_bypB;
  logic [DEPTH-1:0]  w_one, w_clr_oh, w_set_oh;
  assign w_we     = bus.ctrl_writeEnable && !(Z && bus.ctrl_writeReg == '0);
  assign w_set    = bus.ctrl_setBusy && !(Z && bus.ctrl_busyReg == '0);
  assign w_one    = {{(DEPTH-1){1'b0}}, 1'b1};
  assign w_clr_oh = w_we ? w_one << bus.ctrl_writeReg : '0;
  assign w_set_oh = w_set ? w_one << bus.ctrl_busyReg : '0;
  // set beats clear on the same register, so only count a clear it does not cancel
  assign w_inc = w_set && !r_busy[bus.ctrl_busyReg];
  assign w_dec = w_we && r_busy[bus.ctrl_writeReg] && !(w_set && bus.ctrl_busyReg == bus.ctrl_writeReg);
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      if (w_we) r_mem[bus.ctrl_writeReg] <= bus.data_writeReg;
      r_busy  <= (r_busy & ~w_clr_oh) | w_set_oh;
      r_count <= r_count + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
    end
  end
  assign w_zA = Z && bus.ctrl_readRegA == '0;
  assign w_zB = Z && bus.ctrl_readRegB == '0;
`ifdef REGFILE_BYPASS_EN
  assign w_bypA = w_we && !ctrl_reset && bus.ctrl_readRegA == bus.ctrl_writeReg;
  assign w_bypB = w_we && !ctrl_reset && bus.ctrl_readRegB == bus.ctrl_writeReg;
`else
  assign w_bypA = 1'b0;
  assign w_bypB = 1'b0;
`endif
  always_comb begin
    bus.data_readRegA = w_zA ? '0 : w_bypA ? bus.data_writeReg : r_mem[bus.ctrl_readRegA];
    bus.data_readRegB = w_zB ? '0 : w_bypB ? bus.data_writeReg : r_mem[bus.ctrl_readRegB];
    bus.busy_readRegA = !w_bypA && r_busy[bus.ctrl_readRegA];
    bus.busy_readRegB = !w_bypB && r_busy[bus.ctrl_readRegB];
  end
  assign bus.busy_count = r_count;
endmodule
